// File: rtl/tri_cmd_scheduler.sv
// tri_cmd_scheduler: arbitrates three command requesters (triangle, tile flush,
// end-of-frame) onto a byte-wide command FIFO. A granted command is loaded
// whole into a shift register and streamed out MSB first, one byte per
// non-full cycle. Flush and end-of-frame share a single credit that the
// rasterizer returns with draw_next.
module tri_cmd_scheduler #(
  parameter int CMD_BYTES = 60
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tri_valid,
  input  logic [8*CMD_BYTES-1:0] tri_data,
  output logic                   tri_ready,
  input  logic                   flush_valid,
  input  logic [8*CMD_BYTES-1:0] flush_data,
  output logic                   flush_ready,
  input  logic                   eof_valid,
  input  logic [8*CMD_BYTES-1:0] eof_data,
  output logic                   eof_ready,
  input  logic                   triangle_full,
  output logic [7:0]             triangle_wrdata,
  output logic                   triangle_push,
  input  logic                   draw_next,
  output logic                   busy,
  output logic [1:0]             cur_class
);

  localparam int W  = 8 * CMD_BYTES;
  localparam int CW = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_shift;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_class;
  logic            r_credit;

  logic            w_idle;
  logic            w_gnt_tri, w_gnt_flush, w_gnt_eof, w_gnt;
  logic            w_last;
  logic [W-1:0]    w_gnt_data;
  logic [1:0]      w_gnt_class;

  // Readies are gated with rst_n so they drop the instant reset is applied,
  // even though the state register already reads IDLE during reset.
  assign w_idle      = (r_state == IDLE) && rst_n;
  assign w_gnt_tri   = w_idle && tri_valid;
  assign w_gnt_flush = w_idle && !tri_valid && flush_valid && r_credit;
  assign w_gnt_eof   = w_idle && !tri_valid && !flush_valid && eof_valid && r_credit;
  assign w_gnt       = w_gnt_tri || w_gnt_flush || w_gnt_eof;

  assign tri_ready   = w_gnt_tri;
  assign flush_ready = w_gnt_flush;
  assign eof_ready   = w_gnt_eof;

  assign triangle_push   = (r_state == SEND) && !triangle_full;
  assign triangle_wrdata = triangle_push ? r_shift[W-1 -: 8] : 8'h00;
  assign w_last          = triangle_push && (r_cnt == '0);
  assign busy            = (r_state == SEND);
  assign cur_class       = r_class;

  // Select the winner's payload and class code.
  always_comb begin
    w_gnt_data  = tri_data;
    w_gnt_class = 2'd1;
    if (w_gnt_flush) begin
      w_gnt_data  = flush_data;
      w_gnt_class = 2'd2;
    end else if (w_gnt_eof) begin
      w_gnt_data  = eof_data;
      w_gnt_class = 2'd3;
    end
  end

  // Next state: grant leaves IDLE, the push of byte 0 returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt)  w_state_nxt = SEND;
      SEND:    if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Command shift register, byte counter and class; all hold while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_class <= 2'd0;
    end else if (w_gnt) begin
      r_shift <= w_gnt_data;
      r_cnt   <= CW'(CMD_BYTES - 1);
      r_class <= w_gnt_class;
    end else if (triangle_push) begin
      r_shift <= r_shift << 8;
      if (w_last) r_class <= 2'd0;
      else        r_cnt   <= r_cnt - 1'b1;
    end
  end

  // Flush/eof credit: draw_next returning the credit beats a same-cycle grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_credit <= 1'b1;
    else if (draw_next)                r_credit <= 1'b1;
    else if (w_gnt_flush || w_gnt_eof) r_credit <= 1'b0;
  end

endmodule

// File: tb/tb_tri_cmd_scheduler.sv
// Bench for tri_cmd_scheduler: a queue-based command model checks every
// output each cycle; directed scenarios add literal expectations on top.
module tb_tri_cmd_scheduler;
  localparam int NB = 60;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tri_valid = 1'b0, flush_valid = 1'b0, eof_valid = 1'b0;
  logic [W-1:0] tri_data = '0, flush_data = '0, eof_data = '0;
  logic         tri_ready, flush_ready, eof_ready;
  logic         triangle_full = 1'b0;
  logic [7:0]   triangle_wrdata;
  logic         triangle_push;
  logic         draw_next = 1'b0;
  logic         busy;
  logic [1:0]   cur_class;

  tri_cmd_scheduler #(.CMD_BYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .tri_valid(tri_valid), .tri_data(tri_data), .tri_ready(tri_ready),
    .flush_valid(flush_valid), .flush_data(flush_data), .flush_ready(flush_ready),
    .eof_valid(eof_valid), .eof_data(eof_data), .eof_ready(eof_ready),
    .triangle_full(triangle_full), .triangle_wrdata(triangle_wrdata),
    .triangle_push(triangle_push), .draw_next(draw_next),
    .busy(busy), .cur_class(cur_class)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0;

  // model: bytes still to send for the command in flight, its class, credit
  bit         m_busy = 1'b0;
  logic [7:0] m_q[$];
  logic [1:0] m_class = 2'd0;
  bit         m_credit = 1'b1;

  // observation logs for the directed checks
  logic [7:0] obs_bytes[$];
  int         push_cyc[$];
  int         gnt_cyc[$];
  int         gnt_cls[$];
  int         busy_cycles = 0;
  bit         hold = 1'b0;
  bit         last_tr, last_fr, last_er;

  function automatic logic [W-1:0] mk(int s);
    logic [W-1:0] d;
    for (int k = 0; k < NB; k++) d[8*k +: 8] = 8'(k * s + 1);
    return d;
  endfunction

  // top byte 0x00, then 0x28, 0x27, ... counting down (mod 256)
  function automatic logic [W-1:0] mk_t1();
    logic [W-1:0] d;
    for (int k = 0; k < NB; k++) d[8*k +: 8] = (k == NB - 1) ? 8'h00 : 8'(k - 18);
    return d;
  endfunction

  task automatic lit(string nm, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    obs_bytes.delete(); push_cyc.delete(); gnt_cyc.delete(); gnt_cls.delete();
    busy_cycles = 0;
  endtask

  // One cycle: compare at the falling edge, log, advance the model, then
  // return just after the next rising edge so the caller can drive inputs.
  task automatic step();
    logic [14:0]  act, exp;
    logic         e_tr, e_fr, e_er, e_push;
    logic [7:0]   e_wd;
    logic [W-1:0] d;
    @(negedge clk);
    cyc++;
    e_tr = 0; e_fr = 0; e_er = 0; e_push = 0; e_wd = 8'h00;
    if (!rst_n) begin
      m_busy = 0; m_q.delete(); m_class = 2'd0; m_credit = 1;
    end else begin
      e_tr   = !m_busy && tri_valid;
      e_fr   = !m_busy && !tri_valid && flush_valid && m_credit;
      e_er   = !m_busy && !tri_valid && !(flush_valid && m_credit) && eof_valid && m_credit;
      e_push = m_busy && !triangle_full;
      e_wd   = e_push ? m_q[0] : 8'h00;
    end
    exp = {e_tr, e_fr, e_er, e_push, e_wd, m_busy, m_class};
    act = {tri_ready, flush_ready, eof_ready, triangle_push, triangle_wrdata, busy, cur_class};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL cycle %0d outputs: got rdy=%b%b%b push=%b wd=%h busy=%b cls=%0d, expected rdy=%b%b%b push=%b wd=%h busy=%b cls=%0d",
               cyc, act[14], act[13], act[12], act[11], act[10:3], act[2], act[1:0],
               exp[14], exp[13], exp[12], exp[11], exp[10:3], exp[2], exp[1:0]);
    end
    if (triangle_push === 1'b1) begin obs_bytes.push_back(triangle_wrdata); push_cyc.push_back(cyc); end
    if (busy === 1'b1) busy_cycles++;
    if (tri_ready === 1'b1)   begin gnt_cyc.push_back(cyc); gnt_cls.push_back(1); end
    if (flush_ready === 1'b1) begin gnt_cyc.push_back(cyc); gnt_cls.push_back(2); end
    if (eof_ready === 1'b1)   begin gnt_cyc.push_back(cyc); gnt_cls.push_back(3); end
    last_tr = (tri_ready === 1'b1); last_fr = (flush_ready === 1'b1); last_er = (eof_ready === 1'b1);
    if (rst_n) begin
      if (m_busy) begin
        if (!triangle_full) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin m_busy = 0; m_class = 2'd0; end
        end
      end else if (e_tr || e_fr || e_er) begin
        d = e_tr ? tri_data : (e_fr ? flush_data : eof_data);
        for (int k = NB - 1; k >= 0; k--) m_q.push_back(d[8*k +: 8]);
        m_busy  = 1;
        m_class = e_tr ? 2'd1 : (e_fr ? 2'd2 : 2'd3);
      end
      if (draw_next) m_credit = 1;
      else if (e_fr || e_er) m_credit = 0;
    end
    @(posedge clk); #1;
  endtask

  // Run n cycles; unless holding, a requester drops valid once it is granted.
  task automatic run(int n);
    repeat (n) begin
      step();
      if (!hold) begin
        if (last_tr) tri_valid = 0;
        if (last_fr) flush_valid = 0;
        if (last_er) eof_valid = 0;
      end
    end
  endtask

  initial begin
    int g;
    // reset state, with a valid present to show readies stay low
    run(1);
    tri_valid = 1;
    run(1);
    lit("reset_busy", busy, 0);
    lit("reset_tri_ready", tri_ready, 0);

    // single tri, granted on the first edge after reset release
    clear_logs();
    rst_n = 1; tri_data = mk_t1();
    run(71);
    lit("t1_grants", gnt_cyc.size(), 1);
    lit("t1_pushes", obs_bytes.size(), 60);
    lit("t1_byte59", obs_bytes[0], 8'h00);
    lit("t1_byte58", obs_bytes[1], 8'h28);
    lit("t1_byte57", obs_bytes[2], 8'h27);
    lit("t1_byte0", obs_bytes[59], 8'hEE);
    lit("t1_first_push_latency", push_cyc[0] - gnt_cyc[0], 1);
    lit("t1_busy_cycles", busy_cycles, 60);

    // all three valid: tri then flush; eof waits for credit
    clear_logs();
    tri_valid = 1; tri_data = mk(3);
    flush_valid = 1; flush_data = mk(5);
    eof_valid = 1; eof_data = mk(7);
    run(200);
    lit("t2_grants_before_credit", gnt_cyc.size(), 2);
    lit("t2_first_class", gnt_cls[0], 1);
    lit("t2_second_class", gnt_cls[1], 2);
    lit("t2_grant_spacing", gnt_cyc[1] - gnt_cyc[0], 61);
    draw_next = 1; run(1); draw_next = 0;
    run(70);
    lit("t2_grants_after_credit", gnt_cyc.size(), 3);
    lit("t2_third_class", gnt_cls[2], 3);
    flush_valid = 1; flush_data = mk(9);
    run(10);
    lit("t2_no_flush_without_credit", gnt_cyc.size(), 3);
    draw_next = 1; run(1); draw_next = 0;
    run(70);
    lit("t2_flush_after_credit", gnt_cyc.size(), 4);

    // stall for 5 cycles after 10 bytes
    clear_logs();
    tri_valid = 1; tri_data = mk(11);
    run(1);
    g = 0;
    while (obs_bytes.size() < 10 && g < 20) begin run(1); g++; end
    lit("t3_reach_10_pushes", obs_bytes.size(), 10);
    triangle_full = 1;
    run(5);
    lit("t3_no_push_in_stall", obs_bytes.size(), 10);
    triangle_full = 0;
    run(60);
    lit("t3_pushes", obs_bytes.size(), 60);
    lit("t3_send_cycles", busy_cycles, 65);
    lit("t3_resume_byte", obs_bytes[10], 8'h1C);

    // credit race: draw_next with the flush grant keeps the credit
    draw_next = 1; run(1); draw_next = 0;
    clear_logs();
    hold = 1;
    flush_valid = 1; flush_data = mk(13); draw_next = 1;
    run(1);
    draw_next = 0;
    run(150);
    hold = 0; flush_valid = 0;
    lit("t4_flush_grants", gnt_cyc.size(), 2);
    lit("t4_grant_spacing", gnt_cyc[1] - gnt_cyc[0], 61);
    lit("t4_pushes", obs_bytes.size(), 120);

    // reset in the middle of a tri
    clear_logs();
    tri_valid = 1; tri_data = mk(17);
    run(1);
    g = 0;
    while (obs_bytes.size() < 30 && g < 40) begin run(1); g++; end
    rst_n = 0;
    run(1);
    lit("t5_push_dropped", obs_bytes.size(), 30);
    tri_valid = 1;
    run(1);
    rst_n = 1;
    clear_logs();
    run(70);
    lit("t5_regrant", gnt_cyc.size(), 1);
    lit("t5_pushes", obs_bytes.size(), 60);
    lit("t5_first_byte", obs_bytes[0], 8'hEC);
    clear_logs();
    flush_valid = 1; flush_data = mk(21);
    run(70);
    lit("t5_credit_restored", gnt_cyc.size(), 1);

    // back-to-back tri commands
    clear_logs();
    hold = 1; tri_valid = 1; tri_data = mk(19);
    g = 0;
    while (gnt_cyc.size() < 3 && g < 200) begin run(1); g++; end
    tri_valid = 0; hold = 0;
    run(70);
    lit("t6_grants", gnt_cyc.size(), 3);
    lit("t6_spacing_1", gnt_cyc[1] - gnt_cyc[0], 61);
    lit("t6_spacing_2", gnt_cyc[2] - gnt_cyc[1], 61);
    lit("t6_pushes", obs_bytes.size(), 180);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
